offset_corrector: RTL and testbench

//  Removes measured DC offset from the audio sample stream. Sits downstream of the offset

---
 rtl/offset_corrector.sv | 172 +++++++++++++++++
 tb/tb_offset_corrector.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/offset_corrector.sv
// offset_corrector: subtracts a ramped DC offset from audio samples.
// Latches calibrator estimates, ramps toward them, mutes while calibrating.
module offset_corrector #(
  parameter int RAMP_STEP       = 1,
  parameter int CAL_TIMEOUT     = 40000,
  parameter int MUTE_DURING_CAL = 1
) (
  input  logic        audio_clk,
  input  logic        rst_in,
  input  logic        audio_trigger,
  input  logic [15:0] audio_in,
  input  logic        offset_trigger,
  input  logic [15:0] offset_in,
  input  logic        offset_produced,
  output logic [15:0] audio_out,
  output logic        audio_out_valid,
  output logic [15:0] applied_offset,
  output logic        locked,
  output logic        cal_timeout
);

  localparam logic [1:0] BYPASS  = 2'd0;
  localparam logic [1:0] MUTED   = 2'd1;
  localparam logic [1:0] RAMPING = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam int CW = $clog2(CAL_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CAL_TIMEOUT - 1);
  localparam logic signed [17:0] STEP18 = 18'(RAMP_STEP);
  localparam logic [15:0] STEP16 = 16'(RAMP_STEP);

  logic [1:0]    r_state;
  logic [15:0]   r_applied;
  logic [15:0]   r_target;
  logic          r_have;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_out;
  logic          r_valid;
  logic          r_locked;
  logic          r_cal_to;

  logic [1:0]    w_nstate;
  logic [15:0]   w_napplied;
  logic [15:0]   w_ntarget;
  logic          w_nhave;
  logic [CW-1:0] w_ncnt;
  logic          w_nto;

  logic signed [16:0] w_d17;
  logic [15:0]        w_sat;
  logic               w_mute;
  logic signed [17:0] w_rdiff;
  logic [15:0]        w_ramp;

  // Corrected sample: 17-bit difference against the pre-update offset, saturated
  always_comb begin
    w_d17 = $signed({audio_in[15], audio_in})
          - $signed({r_applied[15], r_applied});
    if (w_d17[16] != w_d17[15])
      w_sat = w_d17[16] ? 16'h8000 : 16'h7FFF;
    else
      w_sat = w_d17[15:0];
    w_mute = (r_state == MUTED) && (MUTE_DURING_CAL != 0);
  end

  // One ramp step toward target; final step snaps exactly onto it
  always_comb begin
    w_rdiff = $signed({{2{r_target[15]}}, r_target})
            - $signed({{2{r_applied[15]}}, r_applied});
    if (w_rdiff > STEP18)
      w_ramp = r_applied + STEP16;
    else if (w_rdiff < -STEP18)
      w_ramp = r_applied - STEP16;
    else
      w_ramp = r_target;
  end

  // Control state machine and offset bookkeeping
  always_comb begin
    w_nstate   = r_state;
    w_napplied = r_applied;
    w_ntarget  = r_target;
    w_nhave    = r_have;
    w_ncnt     = '0;
    w_nto      = 1'b0;
    case (r_state)
      BYPASS: begin
        if (offset_produced) begin
          w_ntarget = offset_in;
          w_nhave   = 1'b1;
          w_nstate  = RAMPING;
        end else if (offset_trigger) begin
          w_nstate = MUTED;
        end
      end
      MUTED: begin
        w_ncnt = r_cnt;
        if (offset_produced) begin
          w_ntarget = offset_in;
          w_nhave   = 1'b1;
          w_ncnt    = '0;
          w_nstate  = RAMPING;
        end else if (audio_trigger) begin
          if (r_cnt == CNT_LAST) begin
            w_ncnt   = '0;
            w_nto    = 1'b1;
            w_nstate = r_have ? RAMPING : BYPASS;
          end else begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
      end
      RAMPING: begin
        if (offset_produced) begin
          w_ntarget = offset_in;
        end else if (audio_trigger) begin
          w_napplied = w_ramp;
          if (w_ramp == r_target) w_nstate = LOCKED;
        end else if (r_applied == r_target) begin
          w_nstate = LOCKED;
        end
      end
      default: begin
        if (offset_produced) begin
          w_ntarget = offset_in;
          w_nstate  = RAMPING;
        end else if (offset_trigger) begin
          w_nstate = MUTED;
        end
      end
    endcase
  end

  // State and offset registers
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      r_state   <= BYPASS;
      r_applied <= '0;
      r_target  <= '0;
      r_have    <= 1'b0;
      r_cnt     <= '0;
      r_locked  <= 1'b0;
      r_cal_to  <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_applied <= w_napplied;
      r_target  <= w_ntarget;
      r_have    <= w_nhave;
      r_cnt     <= w_ncnt;
      r_locked  <= (w_nstate == LOCKED);
      r_cal_to  <= w_nto;
    end
  end

  // Output sample register, one cycle behind audio_trigger
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= audio_trigger;
      if (audio_trigger) r_out <= w_mute ? 16'h0000 : w_sat;
    end
  end

  assign audio_out       = r_out;
  assign audio_out_valid = r_valid;
  assign applied_offset  = r_applied;
  assign locked          = r_locked;
  assign cal_timeout     = r_cal_to;

endmodule

// File: tb/tb_offset_corrector.sv
// tb_offset_corrector: directed vectors for offset_corrector.
// Two instances share stimulus: RAMP_STEP 1 (a_*) and 4 (b_*).
module tb_offset_corrector;

  logic        clk = 1'b0;
  logic        rst;
  logic        atrig;
  logic [15:0] ain;
  logic        otrig;
  logic [15:0] oin;
  logic        oprod;

  logic [15:0] a_out, a_app, b_out, b_app;
  logic        a_val, a_lck, a_to, b_val, b_lck, b_to;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  offset_corrector #(
    .RAMP_STEP(1), .CAL_TIMEOUT(8), .MUTE_DURING_CAL(1)
  ) u_a (
    .audio_clk(clk), .rst_in(rst),
    .audio_trigger(atrig), .audio_in(ain),
    .offset_trigger(otrig), .offset_in(oin),
    .offset_produced(oprod),
    .audio_out(a_out), .audio_out_valid(a_val),
    .applied_offset(a_app), .locked(a_lck),
    .cal_timeout(a_to)
  );

  offset_corrector #(
    .RAMP_STEP(4), .CAL_TIMEOUT(8), .MUTE_DURING_CAL(1)
  ) u_b (
    .audio_clk(clk), .rst_in(rst),
    .audio_trigger(atrig), .audio_in(ain),
    .offset_trigger(otrig), .offset_in(oin),
    .offset_produced(oprod),
    .audio_out(b_out), .audio_out_valid(b_val),
    .applied_offset(b_app), .locked(b_lck),
    .cal_timeout(b_to)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    atrig = 1'b0;
    otrig = 1'b0;
    oprod = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic aud(input int x);
    ain   = 16'(x);
    atrig = 1'b1;
    step();
  endtask

  task automatic produce(input int x);
    oin   = 16'(x);
    oprod = 1'b1;
    step();
  endtask

  task automatic lock_a(input string tag);
    int n = 0;
    while (!a_lck && n < 300) begin
      aud(0);
      n++;
    end
    check(tag, int'(a_lck), 1);
  endtask

  int exp_a[7] = '{100, 99, 98, 97, 96, 95, 95};
  int exp_b[7] = '{100, 96, 95, 95, 95, 95, 95};

  initial begin
    rst = 1'b1; atrig = 0; otrig = 0; oprod = 0;
    ain = '0; oin = '0;
    step();
    check("rst_out", int'(a_out), 0);
    check("rst_valid", int'(a_val), 0);
    check("rst_app", int'(a_app), 0);
    check("rst_lock", int'(a_lck), 0);
    check("rst_to", int'(a_to), 0);

    aud(1000);
    check("byp_out", $signed(a_out), 1000);
    check("byp_valid", int'(a_val), 1);
    check("byp_lock", int'(a_lck), 0);
    step();
    check("hold_valid", int'(a_val), 0);
    check("hold_out", $signed(a_out), 1000);

    otrig = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      aud(100);
      check("mute_out", $signed(a_out), 0);
      check("mute_valid", int'(a_val), 1);
    end
    produce(5);
    for (int i = 0; i < 7; i++) begin
      aud(100);
      check("ramp_a_out", $signed(a_out), exp_a[i]);
      check("ramp_b_out", $signed(b_out), exp_b[i]);
      if (i == 3) check("ramp_a_nolock", int'(a_lck), 0);
      if (i == 4) check("ramp_a_lock", int'(a_lck), 1);
      if (i == 0) check("ramp_b_nolock", int'(b_lck), 0);
      if (i == 1) check("ramp_b_lock", int'(b_lck), 1);
    end
    check("ramp_a_app", $signed(a_app), 5);

    produce(-3);
    check("neg_unlock", int'(b_lck), 0);
    aud(0);
    check("neg_b_app1", $signed(b_app), 1);
    check("neg_b_out1", $signed(b_out), -5);
    check("neg_a_app1", $signed(a_app), 4);
    aud(0);
    check("neg_b_app2", $signed(b_app), -3);
    check("neg_b_out2", $signed(b_out), -1);
    check("neg_b_lock", int'(b_lck), 1);
    check("neg_a_app2", $signed(a_app), 3);
    lock_a("neg_a_lock");
    check("neg_a_app", $signed(a_app), -3);

    produce(-100);
    lock_a("satp_lock");
    check("satp_app", $signed(a_app), -100);
    aud(32700);
    check("sat_pos", $signed(a_out), 32767);

    produce(100);
    lock_a("satn_lock");
    aud(-32700);
    check("sat_neg", $signed(a_out), -32768);

    otrig = 1'b1;
    step();
    check("to_unlock", int'(a_lck), 0);
    for (int i = 0; i < 8; i++) begin
      aud(200);
      check("to_mute", $signed(a_out), 0);
      check("to_pulse", int'(a_to), (i == 7) ? 1 : 0);
    end
    aud(200);
    check("to_pulse_end", int'(a_to), 0);
    check("to_out9", $signed(a_out), 100);
    check("to_relock", int'(a_lck), 1);
    check("to_app", $signed(a_app), 100);

    rst = 1'b1;
    step();
    otrig = 1'b1;
    step();
    for (int i = 0; i < 8; i++) aud(50);
    check("byp_to_pulse", int'(a_to), 1);
    aud(-32768);
    check("byp_to_out", $signed(a_out), -32768);
    check("byp_to_lock", int'(a_lck), 0);

    produce(5);
    aud(0);
    aud(0);
    check("mid_app", $signed(a_app), 2);
    rst = 1'b1;
    step();
    check("mid_rst_app", int'(a_app), 0);
    check("mid_rst_out", int'(a_out), 0);
    check("mid_rst_val", int'(a_val), 0);
    check("mid_rst_lock", int'(a_lck), 0);
    aud(7);
    check("mid_byp_out", $signed(a_out), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
